audio_dac_tx: RTL and testbench

Audio output serializer at the tail of the effects chain. It accepts 32-bit signed integer samples from the last effect stage over a valid/ready stream and buffers them in a 4-entry FIFO. Each sample is reduced to the codec word width and transmitted as an I2S frame (BCLK, LRCK, SDATA) to the DAC. The same mono sample is sent on both channels. This block is the transmit counterpart of the codec ADC capture path that feeds the effect chain.

---
 rtl/audio_pkg.sv | 30 +++
 rtl/sample_fifo.sv | 68 ++++++
 rtl/audio_dac_tx.sv | 166 ++++++++++++++++
 tb/tb_audio_dac_tx.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// audio_pkg: shared constants, DAC transmit state type and the saturation
// helper used by the audio output path.
package audio_pkg;

    localparam int unsigned SLOT_W     = 32;
    localparam int unsigned FRAME_BITS = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2
    } dac_state_t;

    // Clamp a signed 32-bit value into the signed range of a w-bit word.
    // The result is still 32 bits wide; callers keep the low w bits.
    function automatic logic [31:0] sat_to_width(input logic signed [31:0] x,
                                                 input int unsigned        w);
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        hi = (32'sd1 <<< (w - 1)) - 32'sd1;
        lo = -(32'sd1 <<< (w - 1));
        if (x > hi) begin
            return hi;
        end else if (x < lo) begin
            return lo;
        end
        return x;
    endfunction

endpackage

// File: rtl/sample_fifo.sv
// sample_fifo: synchronous FIFO with registered full/empty flags.
// DEPTH must be a power of 2 (at least 2). A push on a full FIFO is
// accepted when a pop happens in the same cycle.
module sample_fifo #(
    parameter int unsigned WIDTH = 24,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_din,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_dout,
    output logic             o_full,
    output logic             o_empty
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             r_full;
    logic             r_empty;
    logic [AW:0]      w_count_nxt;
    logic             w_do_push;
    logic             w_do_pop;

    assign w_do_pop  = i_pop && !r_empty;
    assign w_do_push = i_push && (!r_full || w_do_pop);
    assign o_dout    = r_mem[r_rd_ptr];
    assign o_full    = r_full;
    assign o_empty   = r_empty;

    // Next occupancy from this cycle's push/pop pair.
    always_comb begin
        w_count_nxt = r_count;
        case ({w_do_push, w_do_pop})
            2'b10:   w_count_nxt = r_count + 1'b1;
            2'b01:   w_count_nxt = r_count - 1'b1;
            default: w_count_nxt = r_count;
        endcase
    end

    // Pointers, occupancy and flags; flags are registered from next occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == (AW+1)'(DEPTH));
            r_empty <= (w_count_nxt == '0);
        end
    end

    // Storage array; contents need no reset since the pointers gate access.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_din;
    end

endmodule

// File: rtl/audio_dac_tx.sv
// audio_dac_tx: buffers mono samples and serializes them as I2S frames
// (same word on left and right). Optional macro AUDIO_DAC_TX_SAT_EN selects
// saturating word reduction instead of plain truncation.
module audio_dac_tx
    import audio_pkg::*;
#(
    parameter int unsigned SAMPLE_W   = 24,
    parameter int unsigned BCLK_DIV   = 4,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic [31:0] sample_in,
    input  logic        sample_valid,
    output logic        sample_ready,
    output logic        bclk,
    output logic        lrck,
    output logic        sdata,
    output logic [15:0] underrun_cnt
);

    localparam int unsigned HALF = BCLK_DIV / 2;
    localparam int unsigned DW   = (HALF > 1) ? $clog2(HALF) : 1;

    dac_state_t            r_state;
    logic [DW-1:0]         r_div;
    logic                  r_bclk;
    logic                  r_lrck;
    logic                  r_sdata;
    logic [5:0]            r_k;
    logic [FRAME_BITS-1:0] r_frame;
    logic [15:0]           r_underrun;

    logic [SAMPLE_W-1:0]   w_word;
    logic [SAMPLE_W-1:0]   w_fifo_dout;
    logic [SLOT_W-1:0]     w_slot;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_div_end;
    logic                  w_fall;
    logic                  w_wrap;
    logic                  w_load;
    logic [5:0]            w_k_nxt;

`ifdef AUDIO_DAC_TX_SAT_EN
    logic [31:0] w_sat;
    logic        w_unused_sat;
    assign w_sat        = sat_to_width($signed(sample_in), SAMPLE_W);
    assign w_word       = w_sat[SAMPLE_W-1:0];
    assign w_unused_sat = ^w_sat[31:SAMPLE_W];
`else
    logic w_unused_hi;
    assign w_word      = sample_in[SAMPLE_W-1:0];
    assign w_unused_hi = ^sample_in[31:SAMPLE_W];
`endif

    assign w_push       = sample_valid && sample_ready;
    assign sample_ready = !w_full;

    sample_fifo #(
        .WIDTH (SAMPLE_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_din   (w_word),
        .i_pop   (w_pop),
        .o_dout  (w_fifo_dout),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign w_slot    = {w_fifo_dout, {(SLOT_W-SAMPLE_W){1'b0}}};
    assign w_div_end = (r_div == DW'(HALF - 1));
    assign w_fall    = (r_state == RUN) && w_div_end && r_bclk;
    assign w_k_nxt   = r_k + 6'd1;
    assign w_wrap    = w_fall && (w_k_nxt == 6'd0);
    // The IDLE->RUN transition acts as the k=0 edge of the first frame.
    assign w_load    = ((r_state == IDLE) && enable) || (w_wrap && enable);
    assign w_pop     = w_load && !w_empty;

    assign bclk         = r_bclk;
    assign lrck         = r_lrck;
    assign sdata        = r_sdata;
    assign underrun_cnt = r_underrun;

    // Control FSM, BCLK divider and per-falling-edge serializer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_div   <= '0;
            r_bclk  <= 1'b0;
            r_lrck  <= 1'b0;
            r_sdata <= 1'b0;
            r_k     <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_div  <= '0;
                    r_bclk <= 1'b0;
                    r_lrck <= 1'b0;
                    r_sdata <= 1'b0;
                    if (enable) begin
                        r_state <= RUN;
                        r_k     <= '0;
                        r_sdata <= r_frame[0];
                    end
                end
                RUN: begin
                    if (w_div_end) begin
                        r_div <= '0;
                        if (r_bclk) begin
                            r_bclk <= 1'b0;
                            r_k    <= w_k_nxt;
                            if (w_wrap) begin
                                r_lrck  <= 1'b0;
                                r_sdata <= r_frame[0];
                                if (!enable) r_state <= STOP;
                            end else begin
                                // New k = r_k+1, so F[64-k] is F[63-r_k] = F[~r_k].
                                r_lrck  <= w_k_nxt[5];
                                r_sdata <= r_frame[~r_k];
                            end
                        end else begin
                            r_bclk <= 1'b1;
                        end
                    end else begin
                        r_div <= r_div + 1'b1;
                    end
                end
                STOP: begin
                    r_bclk  <= 1'b0;
                    r_lrck  <= 1'b0;
                    r_sdata <= 1'b0;
                    if (w_div_end) begin
                        r_div   <= '0;
                        r_state <= IDLE;
                    end else begin
                        r_div <= r_div + 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Frame word load at k=0 and saturating underrun count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frame    <= '0;
            r_underrun <= '0;
        end else if (w_load) begin
            if (w_pop) begin
                r_frame <= {w_slot, w_slot};
            end else begin
                r_frame <= '0;
                if (r_underrun != 16'hFFFF) r_underrun <= r_underrun + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_audio_dac_tx.sv
// tb_audio_dac_tx: directed self-checking bench for audio_dac_tx with
// SAMPLE_W=24, BCLK_DIV=4. Honors AUDIO_DAC_TX_SAT_EN for expectations.
module tb_audio_dac_tx;

    localparam int unsigned SAMPLE_W = 24;
    localparam int unsigned BCLK_DIV = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic [31:0] sample_in = '0;
    logic        sample_valid = 1'b0;
    logic        sample_ready;
    logic        bclk;
    logic        lrck;
    logic        sdata;
    logic [15:0] underrun_cnt;

    int errors = 0;
    int checks = 0;
    bit tmo = 1'b0;

    always #5 clk = ~clk;

    audio_dac_tx #(
        .SAMPLE_W   (SAMPLE_W),
        .BCLK_DIV   (BCLK_DIV),
        .FIFO_DEPTH (4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .bclk         (bclk),
        .lrck         (lrck),
        .sdata        (sdata),
        .underrun_cnt (underrun_cnt)
    );

    task automatic wait_rise();
        logic prev;
        prev = bclk;
        for (int n = 0; n < 200; n++) begin
            @(posedge clk); #1;
            if (!prev && bclk) return;
            prev = bclk;
        end
        tmo = 1'b1;
    endtask

    task automatic capture_frame(output logic [63:0] sd, output logic [63:0] lr);
        sd = '0;
        lr = '0;
        for (int i = 0; i < 64; i++) begin
            wait_rise();
            sd = {sd[62:0], sdata};
            lr = {lr[62:0], lrck};
        end
    endtask

    task automatic push(input logic [31:0] d);
        sample_in    = d;
        sample_valid = 1'b1;
        @(posedge clk); #1;
        sample_valid = 1'b0;
    endtask

    task automatic do_reset();
        enable       = 1'b0;
        sample_valid = 1'b0;
        rst_n        = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        tmo = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        enable = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (bclk !== 1'b0) begin errors++; $display("FAIL rst_bclk: got %b expected 0", bclk); end
        checks++; if (lrck !== 1'b0) begin errors++; $display("FAIL rst_lrck: got %b expected 0", lrck); end
        checks++; if (sdata !== 1'b0) begin errors++; $display("FAIL rst_sdata: got %b expected 0", sdata); end
        checks++; if (sample_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b expected 1", sample_ready); end
        checks++; if (underrun_cnt !== 16'd0) begin errors++; $display("FAIL rst_underrun: got %0d expected 0", underrun_cnt); end
        rst_n = 1'b1;
        @(posedge clk); #1;
        tmo = 1'b0;
        // Mid-frame reset with a queued sample
        push(32'h007F_FFFF);
        enable = 1'b1;
        repeat (40) wait_rise();
        push(32'h0012_3456);
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (bclk !== 1'b0) begin errors++; $display("FAIL mid_rst_bclk: got %b expected 0", bclk); end
        checks++; if (lrck !== 1'b0) begin errors++; $display("FAIL mid_rst_lrck: got %b expected 0", lrck); end
        checks++; if (sdata !== 1'b0) begin errors++; $display("FAIL mid_rst_sdata: got %b expected 0", sdata); end
        checks++; if (sample_ready !== 1'b1) begin errors++; $display("FAIL mid_rst_ready: got %b expected 1", sample_ready); end
        checks++; if (underrun_cnt !== 16'd0) begin errors++; $display("FAIL mid_rst_underrun: got %0d expected 0", underrun_cnt); end
        enable = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        enable = 1'b1;
        wait_rise();
        checks++; if (underrun_cnt !== 16'd1) begin errors++; $display("FAIL rst_flush: underrun got %0d expected 1", underrun_cnt); end
        checks++; if (tmo !== 1'b0) begin errors++; $display("FAIL reset_timeout: got %b expected 0", tmo); end
        enable = 1'b0;
    endtask

    task automatic test_single();
        logic [63:0] sd, lr;
        do_reset();
        push(32'h0012_3456);
        enable = 1'b1;
        wait_rise();
        checks++; if (sdata !== 1'b0) begin errors++; $display("FAIL single_k0_sdata: got %b expected 0", sdata); end
        checks++; if (lrck !== 1'b0) begin errors++; $display("FAIL single_k0_lrck: got %b expected 0", lrck); end
        capture_frame(sd, lr);
        checks++; if (sd !== 64'h1234_5600_1234_5600) begin errors++; $display("FAIL single_frame: got %h expected 1234560012345600", sd); end
        checks++; if (lr !== 64'h0000_0001_FFFF_FFFE) begin errors++; $display("FAIL single_lrck: got %h expected 00000001fffffffe", lr); end
        checks++; if (underrun_cnt !== 16'd1) begin errors++; $display("FAIL single_underrun: got %0d expected 1", underrun_cnt); end
        checks++; if (sample_ready !== 1'b1) begin errors++; $display("FAIL single_ready: got %b expected 1", sample_ready); end
        checks++; if (tmo !== 1'b0) begin errors++; $display("FAIL single_timeout: got %b expected 0", tmo); end
        enable = 1'b0;
    endtask

    task automatic test_saturation();
        logic [63:0] sd, lr;
        logic [31:0] vin [4];
        logic [31:0] exp_slot [4];
        vin[0] = 32'h0100_0000;
        vin[1] = 32'hFF00_0000;
        vin[2] = 32'h00AB_CDEF;
        vin[3] = 32'hFFFF_8000;
`ifdef AUDIO_DAC_TX_SAT_EN
        exp_slot[0] = 32'h7FFF_FF00;
        exp_slot[1] = 32'h8000_0000;
        exp_slot[2] = 32'h7FFF_FF00;
        exp_slot[3] = 32'hFF80_0000;
`else
        exp_slot[0] = 32'h0000_0000;
        exp_slot[1] = 32'h0000_0000;
        exp_slot[2] = 32'hABCD_EF00;
        exp_slot[3] = 32'hFF80_0000;
`endif
        do_reset();
        for (int i = 0; i < 4; i++) push(vin[i]);
        enable = 1'b1;
        wait_rise();
        for (int i = 0; i < 4; i++) begin
            capture_frame(sd, lr);
            checks++;
            if (sd !== {exp_slot[i], exp_slot[i]}) begin
                errors++;
                $display("FAIL sat_frame%0d: in %h got %h expected %h", i, vin[i], sd, {exp_slot[i], exp_slot[i]});
            end
        end
        checks++; if (tmo !== 1'b0) begin errors++; $display("FAIL sat_timeout: got %b expected 0", tmo); end
        enable = 1'b0;
    endtask

    task automatic test_underrun();
        logic [63:0] sd, lr;
        do_reset();
        enable = 1'b1;
        wait_rise();
        checks++; if (underrun_cnt !== 16'd1) begin errors++; $display("FAIL underrun_first: got %0d expected 1", underrun_cnt); end
        capture_frame(sd, lr);
        checks++; if (sd !== 64'd0) begin errors++; $display("FAIL underrun_frame: got %h expected 0", sd); end
        checks++; if (underrun_cnt !== 16'd2) begin errors++; $display("FAIL underrun_second: got %0d expected 2", underrun_cnt); end
        capture_frame(sd, lr);
        capture_frame(sd, lr);
        checks++; if (underrun_cnt !== 16'd4) begin errors++; $display("FAIL underrun_fourth: got %0d expected 4", underrun_cnt); end
        checks++; if (tmo !== 1'b0) begin errors++; $display("FAIL underrun_timeout: got %b expected 0", tmo); end
        enable = 1'b0;
    endtask

    task automatic test_back_pressure();
        logic [63:0] sd, lr;
        logic [31:0] vin [5];
        logic [31:0] exp_slot [4];
        logic        exp_rdy;
        vin[0] = 32'h0011_1111; vin[1] = 32'h0022_2222; vin[2] = 32'h0033_3333;
        vin[3] = 32'h0044_4444; vin[4] = 32'h0055_5555;
        exp_slot[0] = 32'h1111_1100; exp_slot[1] = 32'h2222_2200;
        exp_slot[2] = 32'h3333_3300; exp_slot[3] = 32'h4444_4400;
        do_reset();
        sample_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            sample_in = vin[i];
            @(posedge clk); #1;
            exp_rdy = (i >= 3) ? 1'b0 : 1'b1;
            checks++;
            if (sample_ready !== exp_rdy) begin
                errors++;
                $display("FAIL bp_ready%0d: got %b expected %b", i, sample_ready, exp_rdy);
            end
        end
        sample_valid = 1'b0;
        enable = 1'b1;
        wait_rise();
        checks++; if (sample_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_after_pop: got %b expected 1", sample_ready); end
        for (int i = 0; i < 4; i++) begin
            capture_frame(sd, lr);
            checks++;
            if (sd !== {exp_slot[i], exp_slot[i]}) begin
                errors++;
                $display("FAIL bp_order%0d: got %h expected %h", i, sd, {exp_slot[i], exp_slot[i]});
            end
        end
        checks++; if (underrun_cnt !== 16'd1) begin errors++; $display("FAIL bp_fifth_rejected: underrun got %0d expected 1", underrun_cnt); end
        checks++; if (tmo !== 1'b0) begin errors++; $display("FAIL bp_timeout: got %b expected 0", tmo); end
        enable = 1'b0;
    endtask

    task automatic test_stop();
        logic [63:0] sd, lr;
        logic [42:0] lr_tail;
        int          hi_cnt;
        do_reset();
        push(32'h0034_5678);
        push(32'h0076_5432);
        enable = 1'b1;
        wait_rise();
        repeat (20) wait_rise();
        enable = 1'b0;
        lr_tail = '0;
        for (int i = 0; i < 43; i++) begin
            wait_rise();
            lr_tail = {lr_tail[41:0], lrck};
        end
        checks++; if (lr_tail !== 43'h0_FFFF_FFFF) begin errors++; $display("FAIL stop_tail_lrck: got %h expected 0ffffffff", lr_tail); end
        repeat (BCLK_DIV) @(posedge clk);
        hi_cnt = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            if (bclk !== 1'b0) hi_cnt++;
        end
        checks++; if (hi_cnt !== 0) begin errors++; $display("FAIL stop_bclk_idle: high samples %0d expected 0", hi_cnt); end
        checks++; if (lrck !== 1'b0) begin errors++; $display("FAIL stop_lrck: got %b expected 0", lrck); end
        checks++; if (sdata !== 1'b0) begin errors++; $display("FAIL stop_sdata: got %b expected 0", sdata); end
        checks++; if (underrun_cnt !== 16'd0) begin errors++; $display("FAIL stop_underrun: got %0d expected 0", underrun_cnt); end
        enable = 1'b1;
        wait_rise();
        capture_frame(sd, lr);
        checks++; if (sd !== 64'h7654_3200_7654_3200) begin errors++; $display("FAIL stop_no_pop: got %h expected 7654320076543200", sd); end
        checks++; if (tmo !== 1'b0) begin errors++; $display("FAIL stop_timeout: got %b expected 0", tmo); end
        enable = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_saturation();
        test_underrun();
        test_back_pressure();
        test_stop();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
